// File: rtl/pll_clken_pkg.sv
// Shared definitions for the PLL clock-enable generator.
// Holds the controller state encoding and the default timing constants.
// Imported by pll_clken_gen.
package pll_clken_pkg;

  // Lock controller states
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  // 171.818 MHz / 96 = 1.78977 MHz strobe
  localparam int unsigned DIV_DEFAULT       = 96;
  // Cycles of SYS_RESET kept asserted after lock is seen
  localparam int unsigned LOCK_HOLD_DEFAULT = 1024;
  // Width of the CE pulse counter
  localparam int unsigned TICK_W            = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk edges from input to output.
// No backpressure; both flops clear to 0 on synchronous reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Resample the asynchronous input twice before it reaches any logic
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_clken_gen.sv
// PLL-lock-qualified reset and divided clock-enable strobe generator.
// Latency: SYS_RESET releases LOCK_HOLD+3 edges after LOCK is sampled; CE/CE_HALF are combinational from RUN.
// No backpressure; RUN=0 freezes the divider. Define CLKEN_HALF_EN to enable the CE_HALF decode.
module pll_clken_gen
  import pll_clken_pkg::*;
#(
  parameter int unsigned DIV       = DIV_DEFAULT,
  parameter int unsigned LOCK_HOLD = LOCK_HOLD_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOCK,
  input  logic              RUN,
  output logic              SYS_RESET,
  output logic              CE,
  output logic              CE_HALF,
  output logic [TICK_W-1:0] TICK_CNT
);

  localparam int unsigned  DW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [15:0]  HOLD_LAST = 16'(LOCK_HOLD - 1);

  state_t              state;
  state_t              state_nxt;
  logic                lock_s;
  logic [15:0]         hold_cnt;
  logic [DW-1:0]       div_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic                sys_reset;
  logic                en;
  logic                ce;

  sync2 u_sync2 (
    .clk   (CLK),
    .reset (RESET),
    .d     (LOCK),
    .q     (lock_s)
  );

  // An enabled cycle: running in ACTIVE and not being reset this edge
  assign en = !RESET && (state == ACTIVE) && RUN;
  assign ce = en && (div_cnt == DIV_LAST);

  // Next-state decode; loss of lock overrides every other transition
  always_comb begin
    state_nxt = state;
    if (!lock_s) begin
      state_nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: state_nxt = HOLD;
        HOLD:      if (hold_cnt == HOLD_LAST) state_nxt = ACTIVE;
        ACTIVE:    state_nxt = ACTIVE;
        default:   state_nxt = WAIT_LOCK;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= WAIT_LOCK;
    else       state <= state_nxt;
  end

  // Hold timer runs only while in HOLD; it starts from 0 on every HOLD entry
  always_ff @(posedge CLK) begin
    if (RESET || !lock_s || (state != HOLD)) hold_cnt <= '0;
    else                                      hold_cnt <= hold_cnt + 16'd1;
  end

  // Divider advances only on enabled cycles and wraps at DIV-1
  always_ff @(posedge CLK) begin
    if (RESET || !lock_s || (state != ACTIVE)) div_cnt <= '0;
    else if (en) begin
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + DW'(1);
    end
  end

  // CE pulse counter; clears on lock loss, wraps naturally at 16 bits
  always_ff @(posedge CLK) begin
    if (RESET || !lock_s) tick_cnt <= '0;
    else if (ce)          tick_cnt <= tick_cnt + 16'd1;
  end

  // Downstream reset lags the state by one register so it is glitch-free
  always_ff @(posedge CLK) begin
    if (RESET) sys_reset <= 1'b1;
    else       sys_reset <= (state != ACTIVE);
  end

`ifdef CLKEN_HALF_EN
  localparam logic [DW-1:0] HALF_LAST = DW'(DIV / 2 - 1);
  assign CE_HALF = en && (div_cnt == HALF_LAST);
`else
  assign CE_HALF = 1'b0;
`endif

  assign CE        = ce;
  assign SYS_RESET = sys_reset;
  assign TICK_CNT  = tick_cnt;

endmodule

// File: tb/tb_pll_clken_gen.sv
// Scoreboard bench for pll_clken_gen: two instances (DIV=96 and DIV=2, both LOCK_HOLD=16)
// share one random/directed stimulus stream and are checked against a streak/phase model.
// Directed checks cover release timing, RUN gap, lock loss, reset restart and counter wrap.
module tb_pll_clken_gen;

  localparam int LH    = 16;
  localparam int DIV_A = 96;
  localparam int DIV_B = 2;
`ifdef CLKEN_HALF_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, lock, run;
  logic        sysr_a, ce_a, ceh_a;
  logic [15:0] tick_a;
  logic        sysr_b, ce_b, ceh_b;
  logic [15:0] tick_b;

  pll_clken_gen #(.DIV(DIV_A), .LOCK_HOLD(LH)) dut_a (
    .CLK(clk), .RESET(reset), .LOCK(lock), .RUN(run),
    .SYS_RESET(sysr_a), .CE(ce_a), .CE_HALF(ceh_a), .TICK_CNT(tick_a)
  );

  pll_clken_gen #(.DIV(DIV_B), .LOCK_HOLD(LH)) dut_b (
    .CLK(clk), .RESET(reset), .LOCK(lock), .RUN(run),
    .SYS_RESET(sysr_b), .CE(ce_b), .CE_HALF(ceh_b), .TICK_CNT(tick_b)
  );

  typedef struct {
    logic        sysr;
    logic        ce;
    logic        ceh;
    logic [15:0] tick;
  } obs_t;

  typedef struct {
    obs_t a;
    obs_t b;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic last_ce_a;

  // Reference model: lock is seen two samples late; ACTIVE once the seen-lock
  // streak covers LOCK_HOLD+1 cycles; CE on every DIV-th enabled ACTIVE cycle.
  int          m_div[2] = '{DIV_A, DIV_B};
  bit          s1[2], s2[2];
  int          streak[2];
  int          en_cnt[2];
  logic [15:0] tick[2];
  bit          sysr[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_init();
    for (int k = 0; k < 2; k++) begin
      s1[k] = 0; s2[k] = 0; streak[k] = 0; en_cnt[k] = 0; tick[k] = 16'h0; sysr[k] = 1;
    end
  endtask

  function automatic bit m_active(int k);
    return streak[k] >= LH + 1;
  endfunction

  function automatic obs_t m_obs(int k);
    obs_t o;
    bit   en;
    int   ph;
    en    = !reset && m_active(k) && run;
    ph    = en_cnt[k] % m_div[k];
    o.sysr = sysr[k];
    o.tick = tick[k];
    o.ce   = en && (ph == m_div[k] - 1);
    o.ceh  = HALF && en && (ph == m_div[k] / 2 - 1);
    return o;
  endfunction

  task automatic m_edge(int k);
    obs_t o;
    bit   act;
    o   = m_obs(k);
    act = m_active(k);
    if (reset) begin
      s1[k] = 0; s2[k] = 0; streak[k] = 0; en_cnt[k] = 0; tick[k] = 16'h0; sysr[k] = 1;
    end else begin
      if (!s2[k]) begin
        streak[k] = 0; en_cnt[k] = 0; tick[k] = 16'h0;
      end else begin
        if (streak[k] < 1000000) streak[k]++;
        if (act && run) en_cnt[k]++;
        if (o.ce) tick[k] = tick[k] + 16'd1;
      end
      sysr[k] = !act;
      s2[k] = s1[k];
      s1[k] = lock;
    end
  endtask

  // One clock cycle: publish expectations for this cycle, then advance the model
  task automatic cycle();
    exp_t e;
    e.a = m_obs(0);
    e.b = m_obs(1);
    sb_q.push_back(e);
    #1;
    last_ce_a = ce_a;
    m_edge(0);
    m_edge(1);
    @(negedge clk);
  endtask

  // Monitor: every cycle the DUTs present outputs, compare with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("a_sys_reset", 32'(sysr_a), 32'(e.a.sysr));
        check("a_ce",        32'(ce_a),   32'(e.a.ce));
        check("a_ce_half",   32'(ceh_a),  32'(e.a.ceh));
        check("a_tick_cnt",  32'(tick_a), 32'(e.a.tick));
        check("b_sys_reset", 32'(sysr_b), 32'(e.b.sysr));
        check("b_ce",        32'(ce_b),   32'(e.b.ce));
        check("b_ce_half",   32'(ceh_b),  32'(e.b.ceh));
        check("b_tick_cnt",  32'(tick_b), 32'(e.b.tick));
      end
    end
  end

  initial begin
    int n;
    int idx;
    reset = 1'b1; lock = 1'b0; run = 1'b0;
    @(posedge clk);
    m_init();
    @(negedge clk);
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    // Release timing: first sampling edge, then SYS_RESET falls LH+3 edges later
    lock = 1'b1; run = 1'b1;
    cycle();
    n = 0;
    while (sysr_a !== 1'b0 && n < 60) begin cycle(); n++; end
    check("release_edges", 32'(n), 32'(LH + 3));

    // 960 enabled ACTIVE cycles (first one already completed) -> 10 CE on DIV=96
    repeat (959) cycle();
    check("tick_after_960", 32'(tick_a), 32'd10);
    check("tick_b_after_960", 32'(tick_b), 32'd480);

    // RUN gap of 7 cycles starting at divider phase 50
    n = 0;
    while ((en_cnt[0] % DIV_A) != 50 && n < 200) begin cycle(); n++; end
    for (idx = 0; idx < 200; idx++) begin
      run = (idx < 7) ? 1'b0 : 1'b1;
      cycle();
      if (last_ce_a) break;
    end
    check("run_gap_ce_offset", 32'(idx), 32'(45 + 7));

    // One-cycle lock drop: SYS_RESET back 3 edges after the low sample
    repeat (30) cycle();
    lock = 1'b0;
    cycle();
    lock = 1'b1;
    n = 0;
    while (sysr_a !== 1'b1 && n < 20) begin cycle(); n++; end
    check("lockloss_sysrst_edges", 32'(n), 32'd3);
    check("lockloss_tick", 32'(tick_a), 32'd0);
    // LOCK is high again from the next sample, so release is LH+3 edges after that
    while (sysr_a !== 1'b0 && n < 80) begin cycle(); n++; end
    check("lockloss_rehold_edges", 32'(n), 32'(1 + LH + 3));

    // Counter wrap: preload 0xFFFF, next CE must wrap to 0
    repeat (20) cycle();
    force dut_a.tick_cnt = 16'hFFFF;
    #1;
    release dut_a.tick_cnt;
    tick[0] = 16'hFFFF;
    n = 0;
    last_ce_a = 1'b0;
    while (!last_ce_a && n < 200) begin cycle(); n++; end
    check("wrap_tick", 32'(tick_a), 32'd0);

    // Reset mid-ACTIVE restarts the full sequence
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n = 0;
    while (sysr_a !== 1'b0 && n < 80) begin cycle(); n++; end
    check("reset_restart_edges", 32'(n), 32'(1 + LH + 3));

    // Random traffic: RUN gaps, occasional lock glitches and resets
    for (int i = 0; i < 3000; i++) begin
      run   = ($urandom_range(0, 3) != 0);
      lock  = ($urandom_range(0, 299) != 0);
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0; lock = 1'b1; run = 1'b1;
    repeat (40) cycle();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
